// File: rtl/inst_fetch.sv
// MIPS instruction fetch unit: owns the PC, reads instruction memory over req/ack and
// holds each instruction for the decoder. Optional feature macro: IF_MISALIGN_TRAP_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        dec_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] if_pc4,
  input  logic [1:0]  jump,
  input  logic        branch_taken,
  input  logic [31:0] jr_addr,
  output logic [31:0] fetch_cnt
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
`endif

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10
  } jump_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] jr_target;
  logic [31:0] j_target;
  logic [31:0] next_pc;
  logic        accept;

  // Next-PC candidates; only consumed on the accepting cycle.
  always_comb begin
    pc4       = pc_q + 32'd4;
    br_off    = {{14{if_instr_q[15]}}, if_instr_q[15:0], 2'b00};
    jr_target = jr_addr & 32'hFFFF_FFFC;
    j_target  = {pc4[31:28], if_instr_q[25:0], 2'b00};
    case (jump)
      JMP_JR:  next_pc = jr_target;
      JMP_J:   next_pc = j_target;
      default: next_pc = branch_taken ? (pc4 + br_off) : pc4;
    endcase
  end

  assign accept = (state_q == S_HOLD) && dec_ready;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_trap_q, misalign_trap_d;
  logic jr_misaligned;
  assign jr_misaligned = (jump == JMP_JR) && (jr_addr[1:0] != 2'b00);
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    pc_d        = pc_q;
    if_instr_d  = if_instr_q;
    fetch_cnt_d = fetch_cnt_q;
`ifdef IF_MISALIGN_TRAP_EN
    misalign_trap_d = misalign_trap_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          if_instr_d = imem_rdata;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (accept) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          pc_d        = next_pc;
          state_d     = S_REQ;
`ifdef IF_MISALIGN_TRAP_EN
          // A misaligned jr is still counted as consumed, but the PC is frozen.
          if (jr_misaligned) begin
            pc_d            = pc_q;
            misalign_trap_d = 1'b1;
            state_d         = S_HALT;
          end
`endif
        end
      end
`ifdef IF_MISALIGN_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      if_instr_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_instr_q  <= if_instr_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_trap_q <= 1'b0;
    else        misalign_trap_q <= misalign_trap_d;
  end
  assign misalign_trap = misalign_trap_q;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == S_HOLD);
  assign if_instr  = if_instr_q;
  assign opcode    = if_instr_q[31:26];
  assign funct     = if_instr_q[5:0];
  assign if_pc4    = pc4;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, reset/trap sequences,
// and randomized fetches checked against a next-PC reference model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        dec_ready;
  logic [31:0] if_instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] if_pc4;
  logic [1:0]  jump;
  logic        branch_taken;
  logic [31:0] jr_addr;
  logic [31:0] fetch_cnt;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .dec_ready    (dec_ready),
    .if_instr     (if_instr),
    .opcode       (opcode),
    .funct        (funct),
    .if_pc4       (if_pc4),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jr_addr      (jr_addr),
    .fetch_cnt    (fetch_cnt)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .misalign_trap(misalign_trap)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  jmp;
    logic        br;
    logic [31:0] jr;
    int          lat;
    int          stall;
    logic [31:0] next;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Next PC derived directly from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr,
                                           input logic [1:0] j, input logic br,
                                           input logic [31:0] jr);
    logic [31:0]        pc4;
    logic signed [15:0] imm16;
    int                 off;
    pc4   = pc + 32'd4;
    imm16 = instr[15:0];
    off   = imm16 * 4;
    if (j == 2'b10)      return jr & 32'hFFFF_FFFC;
    else if (j == 2'b01) return (pc4 & 32'hF000_0000) + (instr % 32'h0400_0000) * 32'd4;
    else if (br)         return pc4 + 32'(off);
    else                 return pc4;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},       32'(imem_req),  32'd0);
    check({tag, "_addr"},      imem_addr,      RESET_PC);
    check({tag, "_valid"},     32'(if_valid),  32'd0);
    check({tag, "_instr"},     if_instr,       32'd0);
    check({tag, "_opcode"},    32'(opcode),    32'd0);
    check({tag, "_funct"},     32'(funct),     32'd0);
    check({tag, "_pc4"},       if_pc4,         RESET_PC + 32'd4);
    check({tag, "_fetch_cnt"}, fetch_cnt,      32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    check({tag, "_trap"},      32'(misalign_trap), 32'd0);
`endif
  endtask

  // Serve one read of exp_pc, acking after lat wait cycles; called at a negedge.
  task automatic do_fetch(input logic [31:0] instr, input int lat);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("imem_req_rise", 32'(imem_req), 32'd1);
    check("imem_addr",     imem_addr,     exp_pc);
    check("valid_in_req",  32'(if_valid), 32'd0);
    for (int i = 0; i < lat; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("addr_stable", imem_addr,     exp_pc);
      check("req_stable",  32'(imem_req), 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("if_valid",  32'(if_valid), 32'd1);
    check("req_low",   32'(imem_req), 32'd0);
    check("if_instr",  if_instr,      instr);
    check("opcode",    32'(opcode),   32'(instr[31:26]));
    check("funct",     32'(funct),    32'(instr[5:0]));
    check("if_pc4",    if_pc4,        exp_pc + 32'd4);
  endtask

  // Stall the decoder, then accept with the given control inputs; called at a negedge.
  task automatic do_accept(input logic [31:0] instr, input logic [1:0] j, input logic br,
                           input logic [31:0] jr, input int stall, input logic [31:0] next);
    for (int i = 0; i < stall; i++) begin
      dec_ready    = 1'b0;
      jump         = 2'($urandom_range(0, 3));
      branch_taken = 1'($urandom_range(0, 1));
      jr_addr      = $urandom;
      imem_ack     = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      @(negedge clk);
      check("stall_valid", 32'(if_valid), 32'd1);
      check("stall_instr", if_instr,      instr);
      check("stall_pc4",   if_pc4,        exp_pc + 32'd4);
      check("stall_cnt",   fetch_cnt,     exp_cnt);
    end
    dec_ready    = 1'b1;
    jump         = j;
    branch_taken = br;
    jr_addr      = jr;
    imem_ack     = 1'b0;
    @(negedge clk);
    dec_ready    = 1'b0;
    jump         = 2'($urandom_range(0, 3));
    branch_taken = 1'($urandom_range(0, 1));
    jr_addr      = $urandom;
    exp_cnt      = exp_cnt + 32'd1;
    exp_pc       = next;
    check("fetch_cnt",      fetch_cnt,     exp_cnt);
    check("valid_after_acc", 32'(if_valid), 32'd0);
    check("req_after_acc",  32'(imem_req), 32'd1);
    check("next_addr",      imem_addr,     exp_pc);
  endtask

  initial begin
    logic [31:0] r_instr;
    logic [31:0] r_jr;
    logic [1:0]  r_j;
    logic        r_br;

    vecs[0]  = '{32'h2008_0005, 2'b00, 1'b0, 32'h0,         0, 0, 32'h0000_0004};
    vecs[1]  = '{32'h1000_003E, 2'b00, 1'b1, 32'h0,         3, 4, 32'h0000_0100};
    vecs[2]  = '{32'h1000_FFFE, 2'b00, 1'b1, 32'h0,         1, 0, 32'h0000_00FC};
    vecs[3]  = '{32'h03E0_0008, 2'b10, 1'b0, 32'h0000_0100, 0, 1, 32'h0000_0100};
    vecs[4]  = '{32'h1000_FFFE, 2'b00, 1'b0, 32'h0,         2, 0, 32'h0000_0104};
    vecs[5]  = '{32'h0320_0008, 2'b10, 1'b0, 32'h4000_0010, 0, 0, 32'h4000_0010};
    vecs[6]  = '{32'h0800_0040, 2'b01, 1'b0, 32'h0,         0, 0, 32'h4000_0100};
    vecs[7]  = '{32'h0800_0040, 2'b10, 1'b1, 32'h0000_0200, 1, 1, 32'h0000_0200};
    vecs[8]  = '{32'h1000_0004, 2'b11, 1'b1, 32'h0,         0, 0, 32'h0000_0214};
    vecs[9]  = '{32'h0BFF_FFFF, 2'b01, 1'b0, 32'h0,         0, 2, 32'h0FFF_FFFC};
    vecs[10] = '{32'h2008_0005, 2'b00, 1'b0, 32'h0,         0, 0, 32'h1000_0000};
    vecs[11] = '{32'h03E0_0008, 2'b10, 1'b0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC};
    vecs[12] = '{32'h2008_0005, 2'b00, 1'b0, 32'h0,         1, 0, 32'h0000_0000};
    vecs[13] = '{32'h1000_FFFE, 2'b00, 1'b1, 32'h0,         0, 0, 32'hFFFF_FFFC};
    vecs[14] = '{32'h1000_0001, 2'b00, 1'b1, 32'h0,         0, 0, 32'h0000_0004};

    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    dec_ready    = 1'b0;
    jump         = 2'b00;
    branch_taken = 1'b0;
    jr_addr      = 32'h0;
    exp_pc       = RESET_PC;
    exp_cnt      = 32'd0;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Directed vectors, chained from RESET_PC.
    for (int v = 0; v < 15; v++) begin
      do_fetch(vecs[v].instr, vecs[v].lat);
      do_accept(vecs[v].instr, vecs[v].jmp, vecs[v].br, vecs[v].jr, vecs[v].stall, vecs[v].next);
    end

`ifndef IF_MISALIGN_TRAP_EN
    // Misaligned jr target has its low bits dropped.
    do_fetch(32'h03E0_0008, 0);
    do_accept(32'h03E0_0008, 2'b10, 1'b0, 32'h0000_0203, 0, 32'h0000_0200);
`endif

    // Randomized fetches against the reference model.
    for (int k = 0; k < 40; k++) begin
      r_instr = $urandom;
      r_j     = 2'($urandom_range(0, 3));
      r_br    = 1'($urandom_range(0, 1));
      r_jr    = $urandom;
`ifdef IF_MISALIGN_TRAP_EN
      r_jr    = r_jr & 32'hFFFF_FFFC;
`endif
      do_fetch(r_instr, $urandom_range(0, 3));
      do_accept(r_instr, r_j, r_br, r_jr, $urandom_range(0, 2),
                ref_next(exp_pc, r_instr, r_j, r_br, r_jr));
    end

    // Reset while a request is outstanding; acks during and just after reset are ignored.
    imem_ack = 1'b0;
    @(negedge clk);
    check("req_outstanding", 32'(imem_req), 32'd1);
    rst_n      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    check_reset_vals("hold_rst");
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_valid", 32'(if_valid), 32'd0);
    check("late_ack_instr", if_instr,      32'd0);
    check("restart_req",    32'(imem_req), 32'd1);
    check("restart_addr",   imem_addr,     RESET_PC);
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    do_fetch(vecs[0].instr, 0);
    do_accept(vecs[0].instr, 2'b00, 1'b0, 32'h0, 0, RESET_PC + 32'd4);

`ifdef IF_MISALIGN_TRAP_EN
    // Misaligned jr traps: PC frozen, fetch halted until reset.
    do_fetch(32'h03E0_0008, 0);
    dec_ready = 1'b1;
    jump      = 2'b10;
    jr_addr   = 32'h0000_0203;
    @(negedge clk);
    dec_ready = 1'b0;
    jump      = 2'b00;
    exp_cnt   = exp_cnt + 32'd1;
    for (int i = 0; i < 4; i++) begin
      check("trap_flag",  32'(misalign_trap), 32'd1);
      check("trap_req",   32'(imem_req),      32'd0);
      check("trap_valid", 32'(if_valid),      32'd0);
      check("trap_addr",  imem_addr,          exp_pc);
      check("trap_cnt",   fetch_cnt,          exp_cnt);
      imem_ack  = 1'($urandom_range(0, 1));
      dec_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_ack  = 1'b0;
    dec_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("trap_rst");
    rst_n   = 1'b1;
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    do_fetch(vecs[0].instr, 1);
    do_accept(vecs[0].instr, 2'b00, 1'b0, 32'h0, 0, RESET_PC + 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
